pll_lock_rst_seq: RTL and testbench

- Parametrised lock supervisor and reset/clock-enable sequencer that sits directly downstream of a Gowin rPLL output clock.
- Filters the PLL LOCK signal and requests a PLL reset when lock does not arrive in time.
- Releases N_CH per-domain synchronous resets in staggered order and generates a programmable clock-enable per channel.
- Used in place of ad-hoc "wait for lock" logic around the RAM and CPU clock PLLs.

---
 rtl/pll_lock_rst_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_seq.sv
// Lock supervisor and staggered reset / clock-enable sequencer for a PLL clock.
// Ports: clk, reset (sync, active-high), lock_in (raw async PLL LOCK),
//   div_i (per-channel divisor), rst_o / ce_o (per-channel reset and enable),
//   pll_rst_o (PLL reset request), ready_o (all channels released),
//   unlock_cnt_o (saturating count of lock losses after release).
module pll_lock_rst_seq #(
    parameter int N_CH        = 3,
    parameter int DIV_W       = 8,
    parameter int LOCK_FILTER = 16,
    parameter int RST_STAGGER = 4,
    parameter int TIMEOUT     = 1000,
    parameter int PLLRST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lock_in,
    input  logic [N_CH*DIV_W-1:0] div_i,
    output logic [N_CH-1:0]       rst_o,
    output logic [N_CH-1:0]       ce_o,
    output logic                  pll_rst_o,
    output logic                  ready_o,
    output logic [7:0]            unlock_cnt_o
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int SW = $clog2(RST_STAGGER + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PW = $clog2(PLLRST_LEN + 1);
    localparam int CW = $clog2(N_CH + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [SW-1:0] STAG_LAST = SW'(RST_STAGGER - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] PLS_LAST  = PW'(PLLRST_LEN - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        FILTER,
        PLLRST,
        RELEASE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic lock_m, lock_s;

    logic [FW-1:0]   filt_q, filt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [SW-1:0]   stag_q, stag_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [N_CH-1:0] rst_q, rst_d;
    logic            ready_q, ready_d;
    logic            pll_rst_q, pll_rst_d;
    logic [7:0]      unlock_q, unlock_d;
    logic            enter_rel;
    logic            lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            state_q   <= WAIT_LOCK;
            filt_q    <= '0;
            tmo_q     <= '0;
            pcnt_q    <= '0;
            stag_q    <= '0;
            ch_q      <= '0;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            pll_rst_q <= 1'b0;
            unlock_q  <= '0;
        end else begin
            lock_m    <= lock_in;
            lock_s    <= lock_m;
            state_q   <= state_d;
            filt_q    <= filt_d;
            tmo_q     <= tmo_d;
            pcnt_q    <= pcnt_d;
            stag_q    <= stag_d;
            ch_q      <= ch_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            pll_rst_q <= pll_rst_d;
            unlock_q  <= unlock_d;
        end
    end

    // ch_q is the index of the next channel to leave reset.
    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        tmo_d     = tmo_q;
        pcnt_d    = pcnt_q;
        stag_d    = stag_q;
        ch_d      = ch_q;
        rst_d     = rst_q;
        ready_d   = ready_q;
        pll_rst_d = pll_rst_q;
        unlock_d  = unlock_q;
        enter_rel = 1'b0;
        lost      = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    tmo_d = '0;
                    if (LOCK_FILTER == 1) begin
                        enter_rel = 1'b1;
                    end else begin
                        state_d = FILTER;
                        filt_d  = FW'(1);
                    end
                end else if (TIMEOUT != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d   = PLLRST;
                        tmo_d     = '0;
                        pcnt_d    = '0;
                        pll_rst_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    filt_d  = '0;
                    tmo_d   = '0;
                end else if (filt_q == FILT_LAST) begin
                    enter_rel = 1'b1;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            PLLRST: begin
                if (pcnt_q == PLS_LAST) begin
                    state_d   = WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    pcnt_d    = '0;
                    tmo_d     = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (ch_q > CH_LAST) begin
                    state_d = RUN;
                end else if (stag_q == STAG_LAST) begin
                    stag_d = '0;
                    ch_d   = ch_q + 1'b1;
                    for (int i = 1; i < N_CH; i++) begin
                        if (ch_q == CW'(i)) rst_d[i] = 1'b0;
                    end
                    if (ch_q == CH_LAST) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    stag_d = stag_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) lost = 1'b1;
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (enter_rel) begin
            state_d  = RELEASE;
            filt_d   = '0;
            stag_d   = '0;
            ch_d     = CW'(1);
            rst_d[0] = 1'b0;
            if (N_CH == 1) ready_d = 1'b1;
        end

        if (lost) begin
            state_d = WAIT_LOCK;
            filt_d  = '0;
            tmo_d   = '0;
            pcnt_d  = '0;
            stag_d  = '0;
            ch_d    = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (unlock_q != 8'hFF) unlock_d = unlock_q + 1'b1;
        end
    end

    // Per-channel enable: divisor captured on the release edge only.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_ch;
        logic [DIV_W-1:0] d_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_n;
        logic             ce_q;

        assign div_ch = div_i[i*DIV_W +: DIV_W];
        assign cnt_n  = (cnt_q == d_q - 1'b1) ? '0 : cnt_q + 1'b1;

        always_ff @(posedge clk) begin
            if (reset) begin
                d_q   <= '0;
                cnt_q <= '0;
                ce_q  <= 1'b0;
            end else if (rst_d[i]) begin
                cnt_q <= '0;
                ce_q  <= 1'b0;
            end else if (rst_q[i]) begin
                d_q   <= div_ch;
                cnt_q <= '0;
                ce_q  <= (div_ch <= DIV_W'(1));
            end else if (d_q <= DIV_W'(1)) begin
                cnt_q <= '0;
                ce_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_n;
                ce_q  <= (cnt_n == d_q - 1'b1);
            end
        end

        assign ce_o[i] = ce_q;
    end

    assign rst_o        = rst_q;
    assign pll_rst_o    = pll_rst_q;
    assign ready_o      = ready_q;
    assign unlock_cnt_o = unlock_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq with a cycle-stamped expectation queue.
// Expectations are queued ahead of time and compared when their cycle arrives.
`timescale 1ns/1ps
module tb_pll_lock_rst_seq;

    localparam int N_CH  = 3;
    localparam int DIV_W = 8;

    localparam int S_RST = 0;
    localparam int S_CE  = 1;
    localparam int S_PLL = 2;
    localparam int S_RDY = 3;
    localparam int S_UNL = 4;
    localparam int S_CE0 = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  lock_in;
    logic [N_CH*DIV_W-1:0] div_i;
    logic [N_CH-1:0]       rst_o;
    logic [N_CH-1:0]       ce_o;
    logic                  pll_rst_o;
    logic                  ready_o;
    logic [7:0]            unlock_cnt_o;

    always #5 clk = ~clk;

    pll_lock_rst_seq dut (
        .clk          (clk),
        .reset        (reset),
        .lock_in      (lock_in),
        .div_i        (div_i),
        .rst_o        (rst_o),
        .ce_o         (ce_o),
        .pll_rst_o    (pll_rst_o),
        .ready_o      (ready_o),
        .unlock_cnt_o (unlock_cnt_o)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   tests_run = 0;
    int   failed    = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_RST:   return 32'(rst_o);
            S_CE:    return 32'(ce_o);
            S_PLL:   return 32'(pll_rst_o);
            S_RDY:   return 32'(ready_o);
            S_UNL:   return 32'(unlock_cnt_o);
            S_CE0:   return 32'(ce_o[0]);
            default: return 32'hDEAD;
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            S_RST:   return "rst_o";
            S_CE:    return "ce_o";
            S_PLL:   return "pll_rst_o";
            S_RDY:   return "ready_o";
            S_UNL:   return "unlock_cnt_o";
            S_CE0:   return "ce_o[0]";
            default: return "?";
        endcase
    endfunction

    task automatic push_exp(input int c, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    // Advance one clock; compare every queued expectation due by now.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc <= cyc) begin
                logic [31:0] o;
                o = obs(sb[k].sel);
                tests_run++;
                assert (sb[k].cyc == cyc && o === sb[k].exp) else begin
                    failed++;
                    $error("FAIL %s@%0d got=%0h exp=%0h",
                           sname(sb[k].sel), sb[k].cyc, o, sb[k].exp);
                end
                sb.delete(k);
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_reset_state(input int c);
        push_exp(c, S_RST, 32'h7);
        push_exp(c, S_CE,  32'h0);
        push_exp(c, S_PLL, 32'h0);
        push_exp(c, S_RDY, 32'h0);
        push_exp(c, S_UNL, 32'h0);
    endtask

    // Returns the cycle treated as "cycle 0" (reset-state, reset low).
    task automatic do_reset(output int t);
        reset = 1'b1;
        push_reset_state(cyc + 2);
        step();
        step();
        reset = 1'b0;
        t = cyc;
    endtask

    int t0, lp, mp, t1, t2, t3, a0;

    initial begin
        reset   = 1'b1;
        lock_in = 1'b0;
        div_i   = {8'd0, 8'd1, 8'd4};
        step();

        // Lock arrives
        do_reset(t0);
        push_exp(t0 + 27, S_RST, 32'h7);
        push_exp(t0 + 28, S_RST, 32'h6);
        push_exp(t0 + 28, S_RDY, 32'h0);
        push_exp(t0 + 30, S_CE,  32'h0);
        push_exp(t0 + 31, S_CE,  32'h1);
        push_exp(t0 + 32, S_RST, 32'h4);
        push_exp(t0 + 32, S_CE,  32'h2);
        push_exp(t0 + 35, S_CE,  32'h3);
        push_exp(t0 + 35, S_RDY, 32'h0);
        push_exp(t0 + 36, S_RST, 32'h0);
        push_exp(t0 + 36, S_RDY, 32'h1);
        push_exp(t0 + 36, S_CE,  32'h6);
        push_exp(t0 + 39, S_CE,  32'h7);
        push_exp(t0 + 39, S_UNL, 32'h0);
        run_to(t0 + 10);
        lock_in = 1'b1;

        // Lock loss in RUN, then full re-release
        lp = t0 + 40;
        push_exp(lp + 2,  S_RST, 32'h0);
        push_exp(lp + 2,  S_RDY, 32'h1);
        push_exp(lp + 3,  S_RST, 32'h7);
        push_exp(lp + 3,  S_CE,  32'h0);
        push_exp(lp + 3,  S_RDY, 32'h0);
        push_exp(lp + 3,  S_UNL, 32'h1);
        push_exp(lp + 18, S_RST, 32'h7);
        push_exp(lp + 19, S_RST, 32'h6);
        push_exp(lp + 22, S_CE,  32'h1);
        push_exp(lp + 23, S_RST, 32'h4);
        push_exp(lp + 26, S_RDY, 32'h0);
        push_exp(lp + 27, S_RST, 32'h0);
        push_exp(lp + 27, S_RDY, 32'h1);
        run_to(lp);
        lock_in = 1'b0;
        step();
        lock_in = 1'b1;

        // Divisor change in RUN ignored until the next release
        push_exp(lp + 34, S_CE0, 32'h1);
        push_exp(lp + 35, S_CE0, 32'h0);
        push_exp(lp + 38, S_CE0, 32'h1);
        run_to(lp + 30);
        div_i[7:0] = 8'd7;
        mp = lp + 40;
        push_exp(mp + 3,  S_UNL, 32'h2);
        push_exp(mp + 3,  S_RST, 32'h7);
        push_exp(mp + 19, S_RST, 32'h6);
        push_exp(mp + 24, S_CE0, 32'h0);
        push_exp(mp + 25, S_CE0, 32'h1);
        push_exp(mp + 26, S_CE0, 32'h0);
        push_exp(mp + 31, S_CE0, 32'h0);
        push_exp(mp + 32, S_CE0, 32'h1);
        run_to(mp);
        lock_in = 1'b0;
        step();
        lock_in = 1'b1;
        run_to(mp + 33);
        lock_in = 1'b0;
        div_i[7:0] = 8'd4;

        // Filter glitch
        do_reset(t1);
        push_exp(t1 + 25, S_RST, 32'h7);
        push_exp(t1 + 33, S_RST, 32'h7);
        push_exp(t1 + 34, S_RST, 32'h6);
        push_exp(t1 + 34, S_UNL, 32'h0);
        run_to(t1 + 5);
        lock_in = 1'b1;
        run_to(t1 + 15);
        lock_in = 1'b0;
        run_to(t1 + 16);
        lock_in = 1'b1;
        run_to(t1 + 36);
        lock_in = 1'b0;

        // Timeout pulses, then reset in the middle of the third pulse
        do_reset(t2);
        push_exp(t2 + 999,  S_PLL, 32'h0);
        push_exp(t2 + 1000, S_PLL, 32'h1);
        push_exp(t2 + 1004, S_RST, 32'h7);
        push_exp(t2 + 1007, S_PLL, 32'h1);
        push_exp(t2 + 1008, S_PLL, 32'h0);
        push_exp(t2 + 2007, S_PLL, 32'h0);
        push_exp(t2 + 2008, S_PLL, 32'h1);
        push_exp(t2 + 2015, S_PLL, 32'h1);
        push_exp(t2 + 2016, S_PLL, 32'h0);
        push_exp(t2 + 3018, S_PLL, 32'h1);
        run_to(t2 + 3018);
        reset = 1'b1;
        push_reset_state(t2 + 3019);
        step();
        reset = 1'b0;
        t3 = cyc;
        push_exp(t3 + 999,  S_PLL, 32'h0);
        push_exp(t3 + 1000, S_PLL, 32'h1);
        run_to(t3 + 1001);

        // Saturating lock-loss counter
        a0 = t3 + 1010;
        push_exp(a0 + 18, S_RST, 32'h6);
        push_exp(a0 + 19, S_UNL, 32'd0);
        push_exp(a0 + 20, S_UNL, 32'd1);
        push_exp(a0 + 18 * 253 + 20, S_UNL, 32'd254);
        push_exp(a0 + 18 * 254 + 19, S_UNL, 32'd254);
        push_exp(a0 + 18 * 254 + 20, S_UNL, 32'd255);
        push_exp(a0 + 18 * 259 + 19, S_RDY, 32'd0);
        push_exp(a0 + 18 * 259 + 20, S_UNL, 32'd255);
        for (int n = 0; n < 260; n++) begin
            run_to(a0 + 18 * n);
            lock_in = 1'b1;
            run_to(a0 + 18 * n + 17);
            lock_in = 1'b0;
        end
        run_to(a0 + 18 * 260 + 5);

        tests_run++;
        assert (sb.size() == 0) else begin
            failed++;
            $error("FAIL pending_queue got=%0d exp=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
